// File: rtl/rf_read_serializer.sv
// rf_read_serializer
//
// Walks registers 0..NREG-1 through the register file's read port. Each word
// is streamed out one bit at a time, MSB first, over a valid/ready link.
//
// Each word costs one READ cycle, which latches rd_data. It is followed by
// WIDTH SHIFT cycles, plus any cycles the sink stalls. After the last bit of
// register NREG-1 is accepted, the machine spends one cycle in DONE, where the
// done pulse is raised, and then returns to IDLE.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       request a full dump (only looked at in IDLE)
//   rd_addr     register file read address (always equals the walk address)
//   rd_data     register file read data, combinational from rd_addr
//   sout        serial data bit (MSB of the shift register)
//   sout_valid  sout holds a bit waiting to be accepted
//   sout_ready  sink accepts the current bit
//   word_last   the current bit is the LSB of its word
//   busy        a dump is in progress (any state other than IDLE)
//   done        one-cycle pulse in the DONE state

module rf_read_serializer #(
    parameter int WIDTH  = 8,
    parameter int NREG   = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              sout,
    output logic              sout_valid,
    input  logic              sout_ready,
    output logic              word_last,
    output logic              busy,
    output logic              done
);

    // The bit counter needs at least one bit, so that WIDTH=1 still gets a
    // counter; in that case it simply sits at 0.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);
    localparam logic [CNT_W-1:0]  TOP_BIT   = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;

    // A bit leaves the block only while shifting and only when the sink
    // takes it. Every other state ignores sout_ready.
    logic accept;
    assign accept = (state_q == S_SHIFT) && sout_ready;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                end
            end

            S_READ: begin
                shreg_d  = rd_data;
                bitcnt_d = TOP_BIT;
                state_d  = S_SHIFT;
            end

            S_SHIFT: begin
                if (accept) begin
                    // Zero fill keeps shreg deterministic once a word drains.
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q - CNT_W'(1);
                    if (bitcnt_q == '0) begin
                        if (addr_q == LAST_ADDR) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = S_READ;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (Moore: a function of the registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        rd_addr    = addr_q;
        sout       = 1'b0;
        sout_valid = 1'b0;
        word_last  = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);

        // Because shreg and bitcnt are registers, sout and word_last cannot
        // change while a stalled bit waits to be accepted.
        if (state_q == S_SHIFT) begin
            sout       = shreg_q[WIDTH-1];
            sout_valid = 1'b1;
            word_last  = (bitcnt_q == '0);
        end
    end

endmodule

// File: doc/rf_read_serializer.md
# rf_read_serializer

Read-side companion to the register file's enable-gated storage: walks all registers through the file's read port and streams each word out serially, MSB first, over a valid/ready link. It sits between the register file read port and a bit-serial debug/readback channel. It is the consumer of the contents that the write path stores.

## Interface
- WIDTH, 8, bits per register word.
- NREG, 4, number of registers read per dump (≥1).
- ADDR_W, 2, read-address width; must satisfy 2^ADDR_W ≥ NREG.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a full dump; sampled only in IDLE.
- rd_addr  output  ADDR_W  register file read address.
- rd_data  input  WIDTH  register file read data, combinational from rd_addr.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout holds a valid bit.
- sout_ready  input  1  sink accepts the bit this cycle.
- word_last  output  1  current bit is the LSB of a word.
- busy  output  1  dump in progress (state ≠ IDLE).
- done  output  1  one-cycle pulse at end of dump.

## Operation
- Reset is synchronous, active-high: the clock is clk and the reset is reset. All state changes happen on the rising edge of clk.
- State machine: IDLE, READ, SHIFT, DONE.
- IDLE: if start=1, go to READ with addr=0. Otherwise stay in IDLE.
- READ: load shreg ← rd_data (addr presented as rd_addr), set bitcnt=WIDTH-1, then go to SHIFT.
- SHIFT: sout=shreg[WIDTH-1], sout_valid=1, word_last=(bitcnt==0).
  - On sout_valid & sout_ready: shreg shifts left by one (zero fill) and bitcnt decrements.
  - If the accepted bit was the last one (bitcnt==0): if addr==NREG-1, go to DONE; else addr←addr+1 and go to READ.
  - Without sout_ready, all state holds and sout/word_last stay stable.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in every state except IDLE. Asserting start in DONE does not restart the dump.
- rd_addr equals addr at all times. rd_data is used only in READ.
- addr never exceeds NREG-1, so there is no wrap-around.
- bitcnt width is clog2(WIDTH), minimum 1.

## Timing
- Reset values: rd_addr=0, sout=0, sout_valid=0, word_last=0, busy=0, done=0. State=IDLE, shreg=0, bitcnt=0.
- Reset has priority over everything else. A reset mid-dump aborts in the next cycle with no done pulse, and the partial word is discarded.
- start accepted at edge N: READ is active during cycle N+1, and the first valid bit appears in cycle N+2.
- Per word: 1 READ cycle plus WIDTH accepted bits. No bubble exists inside a word. Between words there is exactly one cycle with sout_valid=0.
- With sout_ready held at 1, a full dump takes NREG·(WIDTH+1) cycles from the first READ to the last bit. done is asserted in the cycle after the last bit is accepted.
- busy is 1 from the cycle after start is accepted through the DONE cycle inclusive.
- sout_valid is never deasserted while a bit is pending and unaccepted.

## Test plan
- Reset check: apply reset for 2 cycles with start=1 → all outputs 0 and state IDLE. A second start after release begins the dump normally.
- Basic dump (WIDTH=8, NREG=4), registers 0xA5, 0x3C, 0xFF, 0x01, sout_ready=1 → bit stream 10100101 00111100 11111111 00000001.
  - word_last high on bits 8, 16, 24 and 32.
  - One sout_valid=0 gap between words.
  - done pulses exactly once, 36 cycles after the first READ.
- Backpressure: same data, with sout_ready low for 3 cycles after bit 3 and for 2 cycles on a word_last bit.
  - sout, sout_valid and word_last hold steady during the stalls.
  - The stream is identical to the basic dump, and done is delayed by 5 cycles.
- start while busy: pulse start mid-word 2 and again during DONE → no restart and no second done. rd_addr sequence is 0,1,2,3 only.
- Reset mid-operation: assert reset during bit 5 of word 1 → next cycle busy=0 and sout_valid=0, with no done. A fresh start replays from register 0.
- Boundary (WIDTH=1, NREG=1), register 1 → a single bit 1 with word_last=1, then done one cycle later.
